// File: rtl/dac_feed_pkg.sv
// dac_feed_pkg: shared widths, reset constants, LFSR taps and the DAC code saturator
package dac_feed_pkg;
  localparam int DAC_W = 12;
  localparam int SAMPLE_W = 16;
  localparam int VOL_W = 8;
  localparam int VOL_UNITY = 128;
  localparam int ACC_W = 25;
  localparam logic [DAC_W-1:0] DAC_MIDSCALE = 12'h800;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef logic signed [ACC_W-1:0] acc_t;
  function automatic logic [DAC_W-1:0] dac_code(input acc_t r);
    return (r > 25'sd2047) ? 12'hFFF : (r < -25'sd2048) ? 12'h000 : {~r[11], r[10:0]};
  endfunction
endpackage

// File: rtl/dac_feed_fifo.sv
// dac_feed_fifo: sync sample FIFO with registered full/empty and async reset
//   Clk, Reset         clock, async active-high reset
//   wr_en, wr_data     push request (ignored while full)
//   rd_en, rd_data     pop request (ignored while empty), head of queue
//   full, empty        registered flags; full is held high during reset so nothing is accepted
module dac_feed_fifo import dac_feed_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = SAMPLE_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic push, pop;
  assign push = wr_en & ~full;
  assign pop = rd_en & ~empty;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b1;
      empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full <= count_n == (AW+1)'(DEPTH);
      empty <= count_n == '0;
    end
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: buffers audio samples and feeds one gain-scaled 12-bit code per sample period
//   Clk, Reset               clock, async active-high reset
//   SampleIn/Valid/Ready     16-bit signed sample stream into the buffer
//   Volume                   Q1.7 unsigned gain, 128 = unity
//   DivCfg                   clocks per sample period (0 behaves as 1)
//   UnderrunClr, Underrun    sticky empty-at-tick flag and its clear
//   DACin, SampleTick        registered excess-2048 DAC code, period strobe
//   DAC_FEED_DITHER_EN       when defined, rounds with LFSR dither instead of half-up
module dac_sample_feeder import dac_feed_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [SAMPLE_W-1:0] SampleIn,
  input  logic                SampleValid,
  output logic                SampleReady,
  input  logic [VOL_W-1:0]    Volume,
  input  logic [15:0]         DivCfg,
  input  logic                UnderrunClr,
  output logic [DAC_W-1:0]    DACin,
  output logic                SampleTick,
  output logic                Underrun
);
  localparam int VOL_SH = $clog2(VOL_UNITY);
  localparam int OUT_SH = SAMPLE_W - DAC_W;
  logic full, empty, pop, wrap, v1;
  logic [SAMPLE_W-1:0] head;
  logic [15:0] cnt, div_m1;
  logic [3:0] rnd;
  acc_t s_ext, v_ext, prod, q1, rnd_ext, r;
  dac_feed_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .Clk(Clk),
    .Reset(Reset),
    .wr_en(SampleValid),
    .wr_data(SampleIn),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  assign SampleReady = ~full;
  assign pop = SampleTick & ~empty;
  assign div_m1 = (DivCfg == '0) ? '0 : DivCfg - 16'd1;
  // >= rather than == so a DivCfg lowered below the running count wraps at once
  assign wrap = cnt >= div_m1;
  assign s_ext = {{(ACC_W-SAMPLE_W){head[SAMPLE_W-1]}}, head};
  assign v_ext = {{(ACC_W-VOL_W){1'b0}}, Volume};
  assign prod = s_ext * v_ext;
  assign rnd_ext = {{(ACC_W-4){1'b0}}, rnd};
  assign r = (q1 + rnd_ext) >>> OUT_SH;
`ifdef DAC_FEED_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) lfsr <= LFSR_SEED;
    else if (SampleTick) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  assign rnd = lfsr[3:0];
`else
  assign rnd = 4'd8;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      SampleTick <= 1'b0;
      v1 <= 1'b0;
      q1 <= '0;
      DACin <= DAC_MIDSCALE;
      Underrun <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 16'd1;
      SampleTick <= wrap;
      v1 <= pop;
      if (pop) q1 <= prod >>> VOL_SH;
      if (v1) DACin <= dac_code(r);
      if (SampleTick & empty) Underrun <= 1'b1;
      else if (UnderrunClr) Underrun <= 1'b0;
    end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: scoreboard bench with directed samples and hand-computed DAC codes
module tb_dac_sample_feeder;
  logic Clk, Reset, SampleValid, SampleReady, UnderrunClr, SampleTick, Underrun;
  logic [15:0] SampleIn, DivCfg;
  logic [7:0] Volume;
  logic [11:0] DACin;
  int n_checks = 0, n_fail = 0;
  int exp_q[$];
  int pend1 = -1, pend2 = -1;
  bit pend_ur = 0;
  int last_dac = 12'h800;

  dac_sample_feeder #(.FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .SampleIn(SampleIn), .SampleValid(SampleValid),
    .SampleReady(SampleReady), .Volume(Volume), .DivCfg(DivCfg), .UnderrunClr(UnderrunClr),
    .DACin(DACin), .SampleTick(SampleTick), .Underrun(Underrun)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: each tick pops the next expected code (or expects an underrun) and checks DACin two cycles later
  always @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      exp_q.delete();
      pend1 = -1;
      pend2 = -1;
      pend_ur = 0;
      last_dac = 12'h800;
    end else begin
      if (pend_ur) begin
        check("underrun_set", int'(Underrun), 1);
        pend_ur = 0;
      end
      if (pend2 == -2) check("dac_hold", int'(DACin), last_dac);
      else if (pend2 >= 0) begin
        check("dac_out", int'(DACin), pend2);
        last_dac = pend2;
      end
      pend2 = pend1;
      pend1 = -1;
      if (SampleTick) begin
        if (exp_q.size() > 0) pend1 = exp_q.pop_front();
        else begin
          pend1 = -2;
          pend_ur = 1;
        end
      end
    end
  end

  task automatic push_one(input logic [15:0] data, input int code, input int exp_acc);
    int acc;
    @(negedge Clk);
    SampleIn = data;
    SampleValid = 1;
    acc = int'(SampleReady);
    @(posedge Clk);
    #1;
    SampleValid = 0;
    check("push_accept", acc, exp_acc);
    if (exp_acc != 0) exp_q.push_back(code);
  endtask

  task automatic tick_once();
    @(negedge Clk);
    DivCfg = 16'd1;
    @(negedge Clk);
    DivCfg = 16'd1000;
  endtask

  task automatic wait_tick(input int lim);
    int k;
    k = 0;
    @(negedge Clk);
    while (!SampleTick && k < lim) begin
      @(negedge Clk);
      k++;
    end
    check("tick_seen", int'(SampleTick), 1);
  endtask

  task automatic clear_underrun();
    @(negedge Clk);
    UnderrunClr = 1;
    @(negedge Clk);
    UnderrunClr = 0;
    check("underrun_clr", int'(Underrun), 0);
  endtask

  initial begin
    int n;
    Reset = 1;
    SampleValid = 0;
    SampleIn = '0;
    Volume = 8'd128;
    DivCfg = 16'd1000;
    UnderrunClr = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_dacin", int'(DACin), 12'h800);
    check("rst_ready", int'(SampleReady), 0);
    check("rst_tick", int'(SampleTick), 0);
    check("rst_underrun", int'(Underrun), 0);
    Reset = 0;
    @(posedge Clk);
    #1;
    check("ready_after_rst", int'(SampleReady), 1);

    // unity gain, DivCfg=4: tick period and 16'h4000 -> C00
    push_one(16'h4000, 12'hC00, 1);
    DivCfg = 16'd4;
    wait_tick(20);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!SampleTick && n < 20);
    check("tick_period", n, 4);
    DivCfg = 16'd1000;
    repeat (3) @(negedge Clk);
    clear_underrun();

    // rounding overflow saturates high
    push_one(16'h7FFF, 12'hFFF, 1);
    tick_once();
    repeat (3) @(negedge Clk);
    check("no_underrun_sat_hi", int'(Underrun), 0);

    // max gain on most negative sample saturates low
    Volume = 8'd255;
    push_one(16'h8000, 12'h000, 1);
    tick_once();
    repeat (3) @(negedge Clk);
    Volume = 8'd128;

    // fill to full, fifth sample refused, one pop reopens
    push_one(16'h0100, 12'h810, 1);
    push_one(16'hF000, 12'h700, 1);
    push_one(16'h0018, 12'h802, 1);
    push_one(16'hFFF8, 12'h800, 1);
    check("full_ready_low", int'(SampleReady), 0);
    push_one(16'h0555, 12'h855, 0);
    tick_once();
    @(negedge Clk);
    check("ready_after_pop", int'(SampleReady), 1);
    repeat (4) tick_once();
    repeat (4) @(negedge Clk);
    check("underrun_after_drain", int'(Underrun), 1);
    clear_underrun();

    // underrun tick coincident with clear: set wins
    @(negedge Clk);
    DivCfg = 16'd1;
    @(negedge Clk);
    DivCfg = 16'd1000;
    UnderrunClr = 1;
    @(negedge Clk);
    UnderrunClr = 0;
    check("underrun_set_wins", int'(Underrun), 1);
    repeat (3) @(negedge Clk);
    clear_underrun();

    // DivCfg=1 with a push every cycle: one output per cycle
    push_one(16'h0010, 12'h801, 1);
    DivCfg = 16'd1;
    push_one(16'h0020, 12'h802, 1);
    push_one(16'h0030, 12'h803, 1);
    push_one(16'h0040, 12'h804, 1);
    push_one(16'hFFF0, 12'h7FF, 1);
    push_one(16'h0800, 12'h880, 1);
    repeat (6) @(negedge Clk);
    DivCfg = 16'd1000;
    repeat (3) @(negedge Clk);
    clear_underrun();

    // async reset mid-stream discards buffered and in-flight data
    push_one(16'h4000, 12'hC00, 1);
    push_one(16'h4000, 12'hC00, 1);
    DivCfg = 16'd3;
    wait_tick(20);
    @(posedge Clk);
    #3;
    Reset = 1;
    #1;
    check("midrst_dacin", int'(DACin), 12'h800);
    check("midrst_ready", int'(SampleReady), 0);
    DivCfg = 16'd1000;
    repeat (2) @(negedge Clk);
    Reset = 0;
    @(posedge Clk);
    #1;
    check("midrst_ready_back", int'(SampleReady), 1);
    check("midrst_underrun_clr", int'(Underrun), 0);
    tick_once();
    repeat (4) @(negedge Clk);
    check("midrst_empty_underrun", int'(Underrun), 1);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, sample buffer depth (power of 2, >=2).
REQ-002 SHALL have port Clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SampleIn  input  16  signed two's-complement audio sample.
REQ-005 SHALL have port SampleValid  input  1  SampleIn valid.
REQ-006 SHALL have port SampleReady  output  1  buffer can accept a sample.
REQ-007 SHALL have port Volume  input  8  unsigned gain, Q1.7; 128 = unity.
REQ-008 SHALL have port DivCfg  input  16  Clk cycles per sample period; 0 treated as 1.
REQ-009 SHALL have port UnderrunClr  input  1  clears Underrun.
REQ-010 SHALL have port DACin  output  12  excess-2048 code to the delta-sigma DAC, registered.
REQ-011 SHALL have port SampleTick  output  1  one-cycle pulse per sample period.
REQ-012 SHALL have port Underrun  output  1  sticky: a tick found the buffer empty.

Function
REQ-013 SHALL push SampleIn only on a cycle with SampleValid=1 and SampleReady=1.
REQ-014 SHALL drive SampleReady = not full, depending only on registered state (no combinational path from SampleValid or the tick).
REQ-015 SHALL run a divider counter 0..max(DivCfg,1)-1 and assert SampleTick on the cycle the counter wraps to 0.
REQ-016 SHALL, if DivCfg is lowered below the current count, wrap and tick on the next cycle.
REQ-017 SHALL pop one sample per SampleTick when the buffer is non-empty; with push and pop in the same cycle, occupancy stays unchanged.
REQ-018 SHALL NOT bypass the buffer: a tick with the buffer empty is an underrun, even if a push occurs that cycle.
REQ-019 SHALL, on underrun, hold DACin and set Underrun; a set in the same cycle as UnderrunClr SHALL win.
REQ-020 SHALL run a 2-stage datapath: stage 1 computes P = SampleIn * {0,Volume} (signed 25-bit), then Q = P >>> 7 (arithmetic shift).
REQ-021 SHALL, in stage 2, form R = (Q + rnd) >>> 4, saturate R to [-2048,2047], and set DACin = R with its MSB inverted.
REQ-022 SHALL update DACin exactly 2 cycles after the tick that popped the sample.
REQ-023 SHALL apply the Volume value sampled in the popping cycle.
REQ-024 SHALL, with DivCfg=1 and the buffer refilled every cycle, sustain one output per cycle.

Reset
REQ-025 SHALL, while Reset is high, clear buffer pointers and occupancy, divider, pipeline valids and Underrun; DACin=12'h800 (midscale); SampleTick=0; SampleReady=0.
REQ-026 SHALL, after Reset deasserts, raise SampleReady on the first Clk edge.
REQ-027 SHALL discard data in flight on Reset mid-operation; the first tick after reset is an underrun unless a sample was pushed first.

Configuration
REQ-028 SHALL, with macro DAC_FEED_DITHER_EN defined, use rnd = LFSR[3:0].
REQ-029 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on Reset, advancing once per SampleTick.
REQ-030 SHALL, with DAC_FEED_DITHER_EN undefined, use rnd = 8 (round half up) and SHALL contain no LFSR logic.

Structure
REQ-031 SHALL take from shared package dac_feed_pkg the constants DAC_W=12, SAMPLE_W=16, VOL_W=8, VOL_UNITY=128, DAC_MIDSCALE=12'h800, LFSR_SEED=16'hACE1 and the LFSR tap mask.
REQ-032 SHALL implement the buffer as sub-module dac_feed_fifo (sync FIFO, registered full/empty, async reset); the divider, datapath and flags SHALL live in the top level.

Verification
REQ-033 Bench SHALL cover: dither off, Volume=128, DivCfg=4, push 16'h4000 -> SampleTick every 4 cycles; DACin=12'hC00 two cycles after the tick.
REQ-034 Bench SHALL cover: dither off, Volume=128, push 16'h7FFF -> DACin=12'hFFF (rounding overflow saturates).
REQ-035 Bench SHALL cover: dither off, Volume=255, push 16'h8000 -> DACin=12'h000 (negative saturation).
REQ-036 Bench SHALL cover: push 4 samples with no ticks -> SampleReady=0, 5th SampleValid ignored; one tick -> SampleReady=1 next cycle.
REQ-037 Bench SHALL cover: empty buffer, tick -> DACin holds, Underrun=1; UnderrunClr pulse alone -> Underrun=0; UnderrunClr coincident with an underrun tick -> Underrun stays 1.
REQ-038 Bench SHALL cover: Reset asserted mid-stream (async, between edges) -> DACin=12'h800 and SampleReady=0 immediately; buffer empty after release.
